cpu_register_reader: RTL and testbench

Sequential read-out engine for the CPU register file: on a start pulse it walks a contiguous (wrapping) range of register addresses through one register-file read port. It streams each captured value, tagged with its address, over a valid/ready interface. It sits between the register file's combinational read port and any debug or trace consumer, and lets the register file be dumped at up to one register per cycle without stalling the write path.

---
 rtl/cpu_register_reader.sv | 105 ++++++++++
 tb/tb_cpu_register_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_register_reader.sv
// rtl/cpu_register_reader.sv - streams a wrapping range of register-file reads over valid/ready
module cpu_register_reader #(
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter int DATA_WIDTH          = 4,
    localparam int AW = (NUMBER_OF_REGISTERS > 1) ? $clog2(NUMBER_OF_REGISTERS) : 1
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [AW-1:0]                start_address_in,
    input  logic [AW:0]                  count_in,
    output logic [AW-1:0]                read_register_address_out,
    input  logic signed [DATA_WIDTH-1:0] read_data_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic [AW-1:0]                address_out,
    output logic                         last_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         busy_out,
    output logic                         done_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                       state_q;
    logic [AW-1:0]                ptr_q;
    logic [AW:0]                  rem_q;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic [AW-1:0]                addr_q;
    logic                         last_q;
    logic                         valid_q;

    logic [AW-1:0]                ptr_d;
    logic [AW:0]                  rem_d;
    logic                         load;
    logic                         start_oob;

    // Explicit wrap compare so non-power-of-two register counts wrap correctly.
    assign ptr_d     = (ptr_q == AW'(NUMBER_OF_REGISTERS - 1)) ? '0 : ptr_q + AW'(1);
    assign rem_d     = rem_q - (AW+1)'(1);
    assign start_oob = (int'(start_address_in) >= NUMBER_OF_REGISTERS);
    // Load a new element whenever the output slot is empty or being drained this cycle.
    assign load      = (state_q == STREAM) && (rem_q != '0) && (!valid_q || ready_in);

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        if (count_in != '0) begin
                            ptr_q   <= start_oob ? '0 : start_address_in;
                            rem_q   <= count_in;
                            state_q <= STREAM;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                STREAM: begin
                    if (load) begin
                        data_q  <= read_data_in;
                        addr_q  <= ptr_q;
                        last_q  <= (rem_q == (AW+1)'(1));
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_d;
                        rem_q   <= rem_d;
                    end else if (valid_q && ready_in) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            last_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_register_address_out = (state_q == STREAM) ? ptr_q : '0;
    assign data_out    = data_q;
    assign address_out = addr_q;
    assign last_out    = last_q;
    assign valid_out   = valid_q;
    assign busy_out    = (state_q != IDLE);
    assign done_out    = (state_q == DONE);

endmodule

// File: tb/tb_cpu_register_reader.sv
// tb/tb_cpu_register_reader.sv - scoreboard bench for cpu_register_reader
module tb_cpu_register_reader;

    localparam int N  = 8;
    localparam int DW = 4;
    localparam int AW = 3;
    localparam int N2 = 6;

    typedef struct {
        int addr;
        int data;
        int last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_in = 1'b0;
    logic                 start_in = 1'b0;
    logic [AW-1:0]        start_address_in = '0;
    logic [AW:0]          count_in = '0;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] data_out;
    logic [AW-1:0]        address_out;
    logic                 last_out, valid_out, busy_out, done_out;
    logic                 ready_in = 1'b1;

    logic                 start2 = 1'b0;
    logic [AW-1:0]        start_addr2 = '0;
    logic [AW:0]          count2 = '0;
    logic [AW-1:0]        rd_addr2;
    logic signed [DW-1:0] rd_data2;
    logic signed [DW-1:0] data2;
    logic [AW-1:0]        addr2;
    logic                 last2, valid2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int hs_count = 0, done_count = 0, done_cyc = 0, vld_cycles = 0;
    int done2_count = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];

    function automatic logic signed [DW-1:0] reg_val(input int a);
        return (a == 0) ? '0 : DW'(a - 4);
    endfunction

    assign rd_data  = reg_val(int'(rd_addr));
    assign rd_data2 = reg_val(int'(rd_addr2));

    cpu_register_reader #(.NUMBER_OF_REGISTERS(N), .DATA_WIDTH(DW)) dut (
        .clock_in(clk), .reset_in(reset_in), .start_in(start_in),
        .start_address_in(start_address_in), .count_in(count_in),
        .read_register_address_out(rd_addr), .read_data_in(rd_data),
        .data_out(data_out), .address_out(address_out), .last_out(last_out),
        .valid_out(valid_out), .ready_in(ready_in), .busy_out(busy_out),
        .done_out(done_out)
    );

    cpu_register_reader #(.NUMBER_OF_REGISTERS(N2), .DATA_WIDTH(DW)) dut6 (
        .clock_in(clk), .reset_in(reset_in), .start_in(start2),
        .start_address_in(start_addr2), .count_in(count2),
        .read_register_address_out(rd_addr2), .read_data_in(rd_data2),
        .data_out(data2), .address_out(addr2), .last_out(last2),
        .valid_out(valid2), .ready_in(1'b1), .busy_out(busy2),
        .done_out(done2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the N=8 instance: handshake pops, hold stability, done accounting.
    logic                 prev_hold = 1'b0;
    logic signed [DW-1:0] prev_data;
    logic [AW-1:0]        prev_addr;
    logic                 prev_last;
    always @(negedge clk) begin
        if (!reset_in) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", int'(valid_out), 1);
                chk("hold_data", int'(data_out), int'(prev_data));
                chk("hold_addr", int'(address_out), int'(prev_addr));
                chk("hold_last", int'(last_out), int'(prev_last));
            end
            if (valid_out) vld_cycles++;
            if (valid_out && ready_in) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_element: got addr %0d, expected none", address_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("elem_addr", int'(address_out), e.addr);
                    chk("elem_data", int'(data_out), e.data);
                    chk("elem_last", int'(last_out), e.last);
                end
            end
            if (done_out) begin
                done_count++;
                done_cyc = cyc;
                chk("done_queue_empty", exp_q.size(), 0);
                chk("done_valid_low", int'(valid_out), 0);
            end
            prev_hold = valid_out && !ready_in;
            prev_data = data_out;
            prev_addr = address_out;
            prev_last = last_out;
        end
    end

    always @(negedge clk) begin
        if (reset_in) begin
            if (valid2) begin
                if (exp2_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL n6_unexpected_element: got addr %0d, expected none", addr2);
                end else begin
                    exp_t e;
                    e = exp2_q.pop_front();
                    chk("n6_addr", int'(addr2), e.addr);
                    chk("n6_data", int'(data2), e.data);
                    chk("n6_last", int'(last2), e.last);
                end
            end
            if (done2) done2_count++;
        end
    end

    task automatic push_range(input int sa, input int cnt);
        int a;
        a = (sa >= N) ? 0 : sa;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back('{a, int'(reg_val(a)), int'(i == cnt - 1)});
            a = (a == N - 1) ? 0 : a + 1;
        end
    endtask

    task automatic run_dump(input int sa, input int cnt, input bit bp, input int poke);
        int c0, d0, h0, since;
        push_range(sa, cnt);
        d0 = done_count;
        h0 = hs_count;
        vld_cycles = 0;
        ready_in = !bp;
        start_address_in = AW'(sa);
        count_in = cnt[AW:0];
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        c0 = cyc;
        chk("busy_after_start", int'(busy_out), 1);
        since = -1;
        for (int w = 0; w < 200 && done_count == d0; w++) begin
            start_in = (w == poke);
            if (w == poke) begin
                start_address_in = 3'd5;
                count_in = 4'd2;
            end
            if (bp) begin
                if (since < 0 && valid_out) since = 0;
                if (since >= 0) begin
                    ready_in = (since >= 4) && (since % 2 == 0);
                    since++;
                end
            end
            @(posedge clk); #1;
        end
        start_in = 1'b0;
        chk("done_seen", int'(done_count != d0), 1);
        @(negedge clk); #1;
        chk("done_pulses", done_count - d0, 1);
        chk("handshakes", hs_count - h0, cnt);
        chk("busy_after_done", int'(busy_out), 0);
        chk("rd_addr_idle", int'(rd_addr), 0);
        if (!bp) begin
            chk("done_latency", done_cyc - c0, (cnt == 0) ? 0 : cnt + 1);
            chk("valid_cycles", vld_cycles, cnt);
        end
        ready_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_addr", int'(address_out), 0);
        chk("rst_last", int'(last_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_done", int'(done_out), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        reset_in = 1'b1;
        @(posedge clk); #1;

        run_dump(0, 8, 1'b0, -1);
        run_dump(6, 4, 1'b0, -1);
        run_dump(2, 3, 1'b1, -1);
        run_dump(0, 0, 1'b0, 0);
        run_dump(0, 10, 1'b0, -1);
        run_dump(1, 5, 1'b0, 2);

        // Abort a dump after three handshakes with an asynchronous reset.
        push_range(0, 8);
        h0 = hs_count;
        ready_in = 1'b1;
        start_address_in = 3'd0;
        count_in = 4'd8;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (int w = 0; w < 50 && hs_count - h0 < 3; w++) begin
            @(posedge clk); #1;
        end
        chk("abort_handshakes", hs_count - h0, 3);
        #2;
        reset_in = 1'b0;
        #1;
        chk("abort_valid", int'(valid_out), 0);
        chk("abort_data", int'(data_out), 0);
        chk("abort_addr", int'(address_out), 0);
        chk("abort_last", int'(last_out), 0);
        chk("abort_busy", int'(busy_out), 0);
        chk("abort_done", int'(done_out), 0);
        chk("abort_rd_addr", int'(rd_addr), 0);
        exp_q.delete();
        d0 = done_count;
        repeat (3) @(posedge clk);
        #1;
        reset_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_count - d0, 0);
        run_dump(3, 8, 1'b0, -1);

        // Out-of-range start on a six-register file begins at 0 and wraps at 5.
        begin
            int a;
            a = 0;
            for (int i = 0; i < 8; i++) begin
                exp2_q.push_back('{a, int'(reg_val(a)), int'(i == 7)});
                a = (a == N2 - 1) ? 0 : a + 1;
            end
        end
        d0 = done2_count;
        start_addr2 = 3'd7;
        count2 = 4'd8;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int w = 0; w < 100 && done2_count == d0; w++) begin
            @(posedge clk); #1;
        end
        chk("n6_done_seen", done2_count - d0, 1);
        chk("n6_queue_empty", exp2_q.size(), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
